// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: request/response sequencer in front of the shared add/sub ALU.
// ADD/SUB take one ALU pass; MUL is an iterative unsigned shift-add multiply
// reusing the same ALU, result truncated to DATA_WIDTH.
// Optional build macro MUL_EARLY_TERM_EN: MUL stops as soon as no multiplier
// bits remain, so latency tracks the highest set bit of A.
module alu_seq_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req_valid_in,
  input  logic [1:0]            req_op_in,
  input  logic [DATA_WIDTH-1:0] req_a_in,
  input  logic [DATA_WIDTH-1:0] req_b_in,
  output logic                  req_ready_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  zero_out,
  output logic                  sign_out,
  output logic [DATA_WIDTH-1:0] alu_a_out,
  output logic [DATA_WIDTH-1:0] alu_b_out,
  output logic                  alu_op_out,
  input  logic [DATA_WIDTH-1:0] alu_result_in
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE, EXEC, MUL_STEP, DONE} state_t;

  state_t                state, state_nx;
  logic [1:0]            op_r;
  logic [DATA_WIDTH-1:0] a_r, b_r;
  logic [DATA_WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]         cnt;

  logic [DATA_WIDTH-1:0] acc_step, mplier_sh, res_d;
  logic                  res_we, last_step, mul_skip;

  // Accumulator value after this step: add the shifted multiplicand only
  // when the current multiplier bit is set.
  assign acc_step  = mplier[0] ? alu_result_in : acc;
  assign mplier_sh = mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
  // Finish once the remaining multiplier bits are all zero; A==0 skips
  // the step loop entirely.
  assign last_step = (cnt == CW'(DATA_WIDTH - 1)) || (mplier_sh == '0);
  assign mul_skip  = (req_a_in == '0);
`else
  assign last_step = (cnt == CW'(DATA_WIDTH - 1));
  assign mul_skip  = 1'b0;
`endif

  assign req_ready_out = (state == IDLE);
  assign busy_out      = (state != IDLE);
  assign done_out      = (state == DONE);

  // Next state, ALU drive and result write-enable from current state.
  always_comb begin
    state_nx   = state;
    alu_a_out  = '0;
    alu_b_out  = '0;
    alu_op_out = 1'b0;
    res_we     = 1'b0;
    res_d      = '0;
    case (state)
      IDLE: begin
        if (req_valid_in) begin
          if (req_op_in == OP_MUL) begin
            if (mul_skip) begin
              state_nx = DONE;
              res_we   = 1'b1;
            end else begin
              state_nx = MUL_STEP;
            end
          end else begin
            state_nx = EXEC;
          end
        end
      end
      EXEC: begin
        alu_a_out  = a_r;
        alu_b_out  = b_r;
        alu_op_out = (op_r == OP_SUB);
        res_we     = 1'b1;
        res_d      = alu_result_in;
        state_nx   = DONE;
      end
      MUL_STEP: begin
        alu_a_out = acc;
        alu_b_out = mcand;
        if (last_step) begin
          res_we   = 1'b1;
          res_d    = acc_step;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nx;
  end

  // Request latch and multiply working registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_in) begin
            op_r <= req_op_in;
            a_r  <= req_a_in;
            b_r  <= req_b_in;
            if (req_op_in == OP_MUL) begin
              acc    <= '0;
              mcand  <= req_b_in;
              mplier <= req_a_in;
              cnt    <= '0;
            end
          end
        end
        MUL_STEP: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result and flags; held until the next write.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      result_out <= '0;
      zero_out   <= 1'b0;
      sign_out   <= 1'b0;
    end else if (res_we) begin
      result_out <= res_d;
      zero_out   <= (res_d == '0);
      sign_out   <= res_d[DATA_WIDTH-1];
    end
  end

endmodule
